inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage that sits directly downstream of the PC register and upstream of the IF/ID pipeline latch. It takes the registered fetch address and chip-enable from the PC register and runs a req/ack read transaction on the instruction bus. It holds the returned word in a one-entry buffer for IF/ID and raises a stall request to CTRL while the word is not yet available. It also handles pipeline flushes that arrive while a bus transaction is outstanding, and flags misaligned fetch addresses.

## Interface
- No parameters; address and data widths are 32 bits, matching InstAddrBus and InstBus.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- pc_i  in  32  fetch address from the PC register.
- ce_i  in  1  fetch enable from the PC register; 0 means no fetch.
- stall_i  in  6  CTRL stall vector; only bit 1 (IF/ID hold) is used.
- flush_i  in  1  CTRL flush; the current fetch is abandoned.
- mem_req_o  out  1  bus read request, registered.
- mem_addr_o  out  32  bus read address, registered.
- mem_ack_i  in  1  single-cycle acknowledge; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  in  32  bus read data.
- if_pc_o  out  32  address of the instruction presented to IF/ID.
- if_inst_o  out  32  instruction presented to IF/ID; 0 (NOP) when not valid.
- if_valid_o  out  1  if_inst_o/if_pc_o are meaningful this cycle.
- if_adel_o  out  1  address-error-on-load exception for the presented fetch.
- stallreq_o  out  1  request to CTRL to stall the PC and IF.

## Operation
- States: IDLE, WAIT, DRAIN, DONE.
- Held registers: state, mem_req_o, mem_addr_o, req_pc, inst_buf, adel_buf.
- IDLE, with ce_i=1, flush_i=0 and pc_i[1:0]=00: set mem_req_o←1, mem_addr_o←pc_i and req_pc←pc_i, then go to WAIT.
- IDLE, with ce_i=1, flush_i=0 and pc_i[1:0]≠00: make no bus request. Set adel_buf←1, inst_buf←0 and req_pc←pc_i, then go to DONE.
- IDLE, with ce_i=0 or flush_i=1: stay in IDLE.
- WAIT, mem_ack_i=1 with flush_i=0 and ce_i=1: set mem_req_o←0, inst_buf←mem_rdata_i and adel_buf←0, then go to DONE.
- WAIT, mem_ack_i=1 with flush_i=1 or ce_i=0: set mem_req_o←0, discard the data and go to IDLE.
- WAIT, mem_ack_i=0 with flush_i=1 or ce_i=0: go to DRAIN. mem_req_o and mem_addr_o stay unchanged, because a request is never withdrawn before it is acknowledged.
- WAIT, mem_ack_i=0 otherwise: stay in WAIT with the request and address held.
- DRAIN: hold the request until mem_ack_i=1, then set mem_req_o←0, discard the data and go to IDLE. Further flushes in DRAIN have no additional effect.
- DONE, flush_i=1: go to IDLE; the buffered word is dropped.
- DONE, stall_i[1]=0: IF/ID captures the word at this edge; go to IDLE.
- DONE, stall_i[1]=1: stay in DONE with the buffered word held.
- if_valid_o = (state==DONE).
- if_inst_o = inst_buf when valid, else 0.
- if_pc_o = req_pc when valid, else 0.
- if_adel_o = adel_buf when valid, else 0.
- stallreq_o = ce_i and (state≠DONE). This term is combinational.
- Only one transaction is ever outstanding. mem_addr_o[1:0] is always 00 while mem_req_o=1.

## Timing
- Reset values while rst=0: state=IDLE and mem_req_o=0. mem_addr_o, if_pc_o, if_inst_o, req_pc and inst_buf are all 0x00000000. if_valid_o, if_adel_o and adel_buf are 0. stallreq_o = ce_i.
- Reset asserted during WAIT or DRAIN clears mem_req_o immediately. The bus is also reset, so no drain is needed.
- Minimum latency, counting from the cycle pc_i is sampled in IDLE (cycle T):
  - mem_req_o is high in T+1.
  - An ack in T+1 gives DONE (if_valid_o=1) in T+2.
  - Best case is therefore 3 cycles per instruction.
- Each added ack wait cycle adds one cycle of latency.
- stallreq_o is low only in DONE. This lets the PC advance at the same edge where IF/ID captures the word, so the next IDLE sees the next PC.
- A flush asserted in the same cycle as the ack takes priority: the data is discarded.
- After a flush with no transaction outstanding, the fetch of the new PC (new_pc) starts in the next IDLE cycle.

## Test plan
- Aligned fetch with an immediate ack:
  - Stimulus: pc_i=0xBFC00000, ack in the first request cycle returning 0x3C011234.
  - Required: mem_addr_o=0xBFC00000, if_valid_o=1 with if_inst_o=0x3C011234 two cycles after IDLE, stallreq_o=0 only in that cycle.
- Slow memory:
  - Stimulus: ack delayed 4 cycles.
  - Required: mem_req_o and mem_addr_o stay constant for 5 cycles, stallreq_o=1 throughout, DONE one cycle after the ack.
- Flush during WAIT:
  - Stimulus: flush_i=1 while WAIT with ack 2 cycles later carrying 0xDEADBEEF; the next fetch is pc_i=0xBFC00380.
  - Required: the state passes through DRAIN, 0xDEADBEEF never appears on if_inst_o, and the next request address is 0xBFC00380.
- Flush coincident with the ack:
  - Required: the data is discarded, if_valid_o stays 0, and the state returns to IDLE.
- Misaligned PC:
  - Stimulus: pc_i=0xBFC00002.
  - Required: no mem_req_o pulse, if_valid_o=1, if_adel_o=1, if_inst_o=0, if_pc_o=0xBFC00002.
- IF/ID stall and reset:
  - Stimulus: stall_i[1]=1 for 3 cycles while in DONE.
  - Required: if_inst_o is held for 4 cycles, with no new request until stall_i[1]=0.
  - Stimulus: rst=0 asserted during WAIT.
  - Required: mem_req_o=0 immediately.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues one req/ack bus read per PC, buffers the
// returned word for IF/ID and stalls the front end until the word is ready.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        if_adel_o,
  output logic        stallreq_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        adel_buf_q, adel_buf_d;
  logic        abort;
  logic        unused_stall;

  // Only the IF/ID hold bit of the stall vector matters here.
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};
  assign abort        = flush_i | ~ce_i;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    req_pc_d   = req_pc_q;
    inst_buf_d = inst_buf_q;
    adel_buf_d = adel_buf_q;
    case (state_q)
      S_IDLE: begin
        if (ce_i && !flush_i) begin
          req_pc_d = pc_i;
          if (pc_i[1:0] == 2'b00) begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_i;
            state_d    = S_WAIT;
          end else begin
            adel_buf_d = 1'b1;
            inst_buf_d = 32'h0;
            state_d    = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          if (abort) begin
            state_d = S_IDLE;
          end else begin
            inst_buf_d = mem_rdata_i;
            adel_buf_d = 1'b0;
            state_d    = S_DONE;
          end
        end else if (abort) begin
          // Request cannot be withdrawn; wait out the ack and drop the data.
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_DONE: begin
        if (flush_i || !stall_i[1]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      req_pc_q   <= 32'h0;
      inst_buf_q <= 32'h0;
      adel_buf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      req_pc_q   <= req_pc_d;
      inst_buf_q <= inst_buf_d;
      adel_buf_q <= adel_buf_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign if_valid_o = (state_q == S_DONE);
  assign if_inst_o  = if_valid_o ? inst_buf_q : 32'h0;
  assign if_pc_o    = if_valid_o ? req_pc_q : 32'h0;
  assign if_adel_o  = if_valid_o ? adel_buf_q : 1'b0;
  // PC may advance on the same edge IF/ID captures the word.
  assign stallreq_o = ce_i & (state_q != S_DONE);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stimulus pushes expected IF/ID words into a
// queue; a monitor pops and compares whenever IF/ID captures a word.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        if_adel_o;
  logic        stallreq_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   bad_word_seen = 0;

  inst_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .if_pc_o    (if_pc_o),
    .if_inst_o  (if_inst_o),
    .if_valid_o (if_valid_o),
    .if_adel_o  (if_adel_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    e.adel = adel;
    exp_q.push_back(e);
  endtask

  // Monitor: compares whenever IF/ID captures the presented word.
  always @(negedge clk) begin
    if (rst) begin
      if (if_inst_o == 32'hDEADBEEF) bad_word_seen = 1;
      if (!if_valid_o) begin
        check("nop_when_invalid", if_inst_o, 32'h0);
      end else if (!stall_i[1] && !flush_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_valid", {31'h0, if_valid_o}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_pc", if_pc_o, e.pc);
          check("sb_inst", if_inst_o, e.inst);
          check("sb_adel", {31'h0, if_adel_o}, {31'h0, e.adel});
          $display("capture pc=0x%08h inst=0x%08h adel=%0b", if_pc_o, if_inst_o, if_adel_o);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; pc_i = 32'h0; ce_i = 1'b1; stall_i = 6'h0; flush_i = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #2;
    check("rst_req", {31'h0, mem_req_o}, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_valid", {31'h0, if_valid_o}, 32'h0);
    check("rst_pc", if_pc_o, 32'h0);
    check("rst_adel", {31'h0, if_adel_o}, 32'h0);
    check("rst_stallreq_ce1", {31'h0, stallreq_o}, 32'h1);
    ce_i = 1'b0;
    #1;
    check("rst_stallreq_ce0", {31'h0, stallreq_o}, 32'h0);
    tick(); tick();
    rst = 1'b1;

    // Aligned fetch, immediate ack
    pc_i = 32'hBFC00000; ce_i = 1'b1;
    tick();
    check("t1_req", {31'h0, mem_req_o}, 32'h1);
    check("t1_addr", mem_addr_o, 32'hBFC00000);
    check("t1_stallreq_wait", {31'h0, stallreq_o}, 32'h1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h3C011234;
    push(32'hBFC00000, 32'h3C011234, 1'b0);
    tick();
    mem_ack_i = 1'b0;
    check("t1_valid", {31'h0, if_valid_o}, 32'h1);
    check("t1_inst", if_inst_o, 32'h3C011234);
    check("t1_stallreq_done", {31'h0, stallreq_o}, 32'h0);
    tick();
    check("t1_stallreq_idle", {31'h0, stallreq_o}, 32'h1);
    check("t1_req_idle", {31'h0, mem_req_o}, 32'h0);
    ce_i = 1'b0;
    tick();

    // Slow memory: ack in the fifth request cycle
    pc_i = 32'hBFC00004; ce_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_req_held", {31'h0, mem_req_o}, 32'h1);
      check("t2_addr_held", mem_addr_o, 32'hBFC00004);
      check("t2_stallreq", {31'h0, stallreq_o}, 32'h1);
      tick();
    end
    check("t2_req_last", {31'h0, mem_req_o}, 32'h1);
    check("t2_valid_before_ack", {31'h0, if_valid_o}, 32'h0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h8C020010;
    push(32'hBFC00004, 32'h8C020010, 1'b0);
    tick();
    mem_ack_i = 1'b0;
    check("t2_valid", {31'h0, if_valid_o}, 32'h1);
    check("t2_inst", if_inst_o, 32'h8C020010);
    tick();
    ce_i = 1'b0;
    tick();

    // Flush during WAIT, ack two cycles later
    pc_i = 32'hBFC00008; ce_i = 1'b1;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; pc_i = 32'hBFC00380;
    check("t3_drain_req", {31'h0, mem_req_o}, 32'h1);
    check("t3_drain_addr", mem_addr_o, 32'hBFC00008);
    tick();
    check("t3_drain_req2", {31'h0, mem_req_o}, 32'h1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    check("t3_idle_req", {31'h0, mem_req_o}, 32'h0);
    check("t3_idle_valid", {31'h0, if_valid_o}, 32'h0);
    tick();
    check("t3_new_req", {31'h0, mem_req_o}, 32'h1);
    check("t3_new_addr", mem_addr_o, 32'hBFC00380);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h24420001;
    push(32'hBFC00380, 32'h24420001, 1'b0);
    tick();
    mem_ack_i = 1'b0;
    check("t3_new_valid", {31'h0, if_valid_o}, 32'h1);
    tick();
    ce_i = 1'b0;
    tick();

    // Flush coincident with ack
    pc_i = 32'hBFC00010; ce_i = 1'b1;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111; flush_i = 1'b1;
    tick();
    mem_ack_i = 1'b0; flush_i = 1'b0; ce_i = 1'b0;
    check("t4_valid", {31'h0, if_valid_o}, 32'h0);
    check("t4_req", {31'h0, mem_req_o}, 32'h0);
    tick();
    check("t4_valid2", {31'h0, if_valid_o}, 32'h0);
    check("t4_req2", {31'h0, mem_req_o}, 32'h0);

    // Misaligned PC
    pc_i = 32'hBFC00002; ce_i = 1'b1;
    push(32'hBFC00002, 32'h0, 1'b1);
    tick();
    check("t5_no_req", {31'h0, mem_req_o}, 32'h0);
    check("t5_valid", {31'h0, if_valid_o}, 32'h1);
    check("t5_adel", {31'h0, if_adel_o}, 32'h1);
    check("t5_inst", if_inst_o, 32'h0);
    check("t5_pc", if_pc_o, 32'hBFC00002);
    tick();
    ce_i = 1'b0;
    check("t5_no_req2", {31'h0, mem_req_o}, 32'h0);
    tick();

    // IF/ID stall held three cycles in DONE
    pc_i = 32'hBFC00020; ce_i = 1'b1;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hAABBCCDD; stall_i = 6'b000010;
    push(32'hBFC00020, 32'hAABBCCDD, 1'b0);
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("t6_hold_valid", {31'h0, if_valid_o}, 32'h1);
      check("t6_hold_inst", if_inst_o, 32'hAABBCCDD);
      check("t6_hold_no_req", {31'h0, mem_req_o}, 32'h0);
      tick();
    end
    stall_i = 6'h0;
    check("t6_release_inst", if_inst_o, 32'hAABBCCDD);
    tick();
    ce_i = 1'b0;
    check("t6_after_valid", {31'h0, if_valid_o}, 32'h0);
    tick();

    // Async reset during WAIT
    pc_i = 32'hBFC00030; ce_i = 1'b1;
    tick();
    check("t7_req", {31'h0, mem_req_o}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("t7_rst_req", {31'h0, mem_req_o}, 32'h0);
    check("t7_rst_addr", mem_addr_o, 32'h0);
    check("t7_rst_stallreq", {31'h0, stallreq_o}, 32'h1);
    ce_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t7_after_req", {31'h0, mem_req_o}, 32'h0);

    check("bad_word_never_shown", {31'h0, bad_word_seen}, 32'h0);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
